// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, size codes and constants for arbitro_memoria_dados
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic SZ_HALF   = 1'b0;
  localparam logic SZ_WORD   = 1'b1;
  localparam int   HALF_STEP = 2;
  localparam int   HALF_W    = 16;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant with a pointer that moves only on accept
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio_1;

  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || !prio_1)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

  // after granting req0, req1 gets priority next time both ask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_1 <= 1'b0;
    end else if (accept) begin
      prio_1 <= grant[0];
    end
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// rtl/arbitro_memoria_dados.sv - two-requester arbiter that splits word commands into halfword
// accesses to memoria_dados and reassembles word reads
module arbitro_memoria_dados
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic              req0_word,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic              req1_word,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dados_escrita,
  output logic              mem_ler,
  output logic              mem_escrever,
  input  logic [DATA_W-1:0] mem_dados_leitura
);

  state_t            state;
  logic [1:0]        valid_vec;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              sel_write;
  logic              sel_word;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cmd_owner;
  logic              cmd_write;
  logic              cmd_word;
  logic [ADDR_W-1:0] cmd_addr;
  logic [HALF_W-1:0] cmd_wdata_hi;
  logic [HALF_W-1:0] lo_half;
  logic [DATA_W-1:0] wr_lo_ext;
  logic [DATA_W-1:0] wr_hi_ext;
  logic [DATA_W-1:0] word_rdata;
  logic [DATA_W-1:0] resp_data;

  assign valid_vec  = {req1_valid, req0_valid};
  assign accept     = (state == IDLE) && (valid_vec != 2'b00);
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];

  rr_arbiter_2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid_vec),
    .accept (accept),
    .grant  (grant)
  );

  assign sel       = grant[1];
  assign sel_write = sel ? req1_write : req0_write;
  assign sel_word  = sel ? req1_word  : req0_word;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;

  // memoria_dados already sign-extends halfword reads; a word keeps only the raw halves
  always_comb begin
    wr_lo_ext                   = '0;
    wr_lo_ext[HALF_W-1:0]       = sel_wdata[HALF_W-1:0];
    wr_hi_ext                   = '0;
    wr_hi_ext[HALF_W-1:0]       = cmd_wdata_hi;
    word_rdata                  = '0;
    word_rdata[2*HALF_W-1:0]    = {mem_dados_leitura[HALF_W-1:0], lo_half};
    resp_data                   = '0;
    if (!cmd_write) begin
      resp_data = (state == ACC1) ? word_rdata : mem_dados_leitura;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cmd_owner         <= 1'b0;
      cmd_write         <= 1'b0;
      cmd_word          <= 1'b0;
      cmd_addr          <= '0;
      cmd_wdata_hi      <= '0;
      lo_half           <= '0;
      mem_endereco      <= '0;
      mem_dados_escrita <= '0;
      mem_ler           <= 1'b0;
      mem_escrever      <= 1'b0;
      req0_rvalid       <= 1'b0;
      req0_rdata        <= '0;
      req1_rvalid       <= 1'b0;
      req1_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_owner         <= sel;
            cmd_write         <= sel_write;
            cmd_word          <= sel_word;
            cmd_addr          <= sel_addr;
            cmd_wdata_hi      <= sel_wdata[2*HALF_W-1:HALF_W];
            mem_endereco      <= sel_addr;
            mem_dados_escrita <= wr_lo_ext;
            mem_ler           <= !sel_write;
            mem_escrever      <= sel_write;
            state             <= ACC0;
          end
        end
        ACC0: begin
          lo_half <= mem_dados_leitura[HALF_W-1:0];
          if (cmd_word == SZ_WORD) begin
            mem_endereco      <= cmd_addr + ADDR_W'(HALF_STEP);
            mem_dados_escrita <= wr_hi_ext;
            state             <= ACC1;
          end else begin
            mem_endereco      <= '0;
            mem_dados_escrita <= '0;
            mem_ler           <= 1'b0;
            mem_escrever      <= 1'b0;
            req0_rvalid       <= !cmd_owner;
            req1_rvalid       <= cmd_owner;
            if (cmd_owner) req1_rdata <= resp_data;
            else           req0_rdata <= resp_data;
            state             <= RESP;
          end
        end
        ACC1: begin
          mem_endereco      <= '0;
          mem_dados_escrita <= '0;
          mem_ler           <= 1'b0;
          mem_escrever      <= 1'b0;
          req0_rvalid       <= !cmd_owner;
          req1_rvalid       <= cmd_owner;
          if (cmd_owner) req1_rdata <= resp_data;
          else           req0_rdata <= resp_data;
          state             <= RESP;
        end
        default: begin
          req0_rvalid <= 1'b0;
          req0_rdata  <= '0;
          req1_rvalid <= 1'b0;
          req1_rdata  <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
